// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the pipeline control bundle.
package cpu_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    // Control bundle carried from decode through the EX/MEM and MEM stages.
    typedef struct packed {
        logic jump;
        logic branch;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic regWrite;
    } ctrl_t;

endpackage

// File: rtl/data_mem.sv
// Single-port word-addressed RAM with registered read port.
// A simultaneous read and write of the same word returns the old word.
module data_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Storage array: no reset, contents survive rst.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: clear has priority, otherwise capture when enabled, else hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: branch/jump redirect, data-memory access, fault
// tracking, store counting and the MEM/WB pipeline register.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jumpI,
    input  logic                  branchI,
    input  logic                  zfI,
    input  logic                  memReadI,
    input  logic                  memWriteI,
    input  logic                  memToRegI,
    input  logic                  regWriteI,
    input  logic [WORD_W-1:0]     aluResultI,
    input  logic [WORD_W-1:0]     readData2I,
    input  logic [REG_ADDR_W-1:0] writeRegisterI,
    input  logic [WORD_W-1:0]     branchDirI,
    input  logic [WORD_W-1:0]     jumpDirI,
    input  logic                  stallI,
    input  logic                  flushI,
    output logic                  pcSrcO,
    output logic [WORD_W-1:0]     pcTargetO,
    output logic                  flushUpstreamO,
    output logic                  regWriteO,
    output logic                  memToRegO,
    output logic [WORD_W-1:0]     readDataO,
    output logic [WORD_W-1:0]     aluResultO,
    output logic [REG_ADDR_W-1:0] writeRegisterO,
    output logic                  faultO,
    output logic [15:0]           storeCountO
);

    ctrl_t ctrl;
    assign ctrl = '{jump: jumpI, branch: branchI, memRead: memReadI,
                    memWrite: memWriteI, memToReg: memToRegI, regWrite: regWriteI};

    logic [ADDR_W-1:0] word_idx;
    logic              addr_ok;
    logic              advance;
    logic              store_commit;
    logic              load_ok;
    logic              bad_access;

    // An access is legal only when word aligned and inside the array.
    assign word_idx = aluResultI[ADDR_W+1:2];
    assign addr_ok  = (aluResultI[1:0] == 2'b00) && (aluResultI[WORD_W-1:ADDR_W+2] == '0);

    // The instruction moves forward only when neither held nor killed.
    assign advance      = !stallI && !flushI;
    assign store_commit = ctrl.memWrite && addr_ok && advance && !rst;
    assign load_ok      = ctrl.memRead && addr_ok;
    assign bad_access   = (ctrl.memRead || ctrl.memWrite) && !addr_ok;

    // Redirect: jump outranks a taken branch.
    always_comb begin
        pcSrcO    = ctrl.jump || (ctrl.branch && zfI);
        pcTargetO = '0;
        if (ctrl.jump) begin
            pcTargetO = jumpDirI;
        end else if (pcSrcO) begin
            pcTargetO = branchDirI;
        end
        flushUpstreamO = pcSrcO;
    end

    // Read data register lives in the RAM; it follows the MEM/WB hold/clear rules.
    data_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_data_mem (
        .clk_i  (clk),
        .rst_i  (rst),
        .we_i   (store_commit),
        .re_i   (!stallI),
        .clr_i  (flushI || (!stallI && !load_ok)),
        .addr_i (word_idx),
        .wdata_i(readData2I),
        .rdata_o(readDataO)
    );

    logic                  reg_write_q,  reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [WORD_W-1:0]     alu_result_q, alu_result_d;
    logic [REG_ADDR_W-1:0] write_reg_q,  write_reg_d;
    logic                  fault_q,      fault_d;
    logic [15:0]           store_cnt_q,  store_cnt_d;

    // Next-state for MEM/WB fields, fault flag and store counter.
    always_comb begin
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_result_d = alu_result_q;
        write_reg_d  = write_reg_q;
        fault_d      = fault_q;
        store_cnt_d  = store_cnt_q;
        if (flushI) begin
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            alu_result_d = '0;
            write_reg_d  = '0;
        end else if (!stallI) begin
            reg_write_d  = ctrl.regWrite;
            mem_to_reg_d = ctrl.memToReg;
            alu_result_d = aluResultI;
            write_reg_d  = writeRegisterI;
            fault_d      = fault_q || bad_access;
        end
        if (store_commit) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
    end

    // MEM/WB state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
            fault_q      <= 1'b0;
            store_cnt_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            fault_q      <= fault_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    assign regWriteO      = reg_write_q;
    assign memToRegO      = mem_to_reg_q;
    assign aluResultO     = alu_result_q;
    assign writeRegisterO = write_reg_q;
    assign faultO         = fault_q;
    assign storeCountO    = store_cnt_q;

endmodule
